controller_num_entry: RTL and testbench

Multi-digit number-entry engine for the calculator controller. It accepts per-key digit/edit commands from the parse stage and buffers up to DIGITS BCD/hex nibbles with a sign. On commit it serially converts the buffer to a two's-complement binary operand and hands it to the operand stack over a valid/ready handshake. It generalises single-digit decode to a parametrised radix, depth and width, and adds edit, overflow and flow-control behaviour.

---
 rtl/controller_num_entry_pkg.sv | 18 +
 rtl/controller_num_mac.sv | 26 ++
 rtl/controller_num_entry.sv | 147 ++++++++++++++
 tb/tb_controller_num_entry.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/controller_num_entry_pkg.sv
// Shared command encodings, FSM state codes and blank-nibble constant for number entry.
package controller_num_entry_pkg;

   localparam logic [2:0] NE_OP_DIGIT  = 3'd0;
   localparam logic [2:0] NE_OP_BKSP   = 3'd1;
   localparam logic [2:0] NE_OP_CLEAR  = 3'd2;
   localparam logic [2:0] NE_OP_NEG    = 3'd3;
   localparam logic [2:0] NE_OP_COMMIT = 3'd4;

   localparam logic [3:0] NE_BLANK = 4'hf;

   typedef enum logic [1:0] {
      S_ENTRY = 2'd0,
      S_CONV  = 2'd1,
      S_OUT   = 2'd2
   } ne_state_t;

endpackage

// File: rtl/controller_num_mac.sv
// One conversion step acc*RADIX+digit, saturated to 2^(W-1)-1; combinational, no flow control.
module controller_num_mac #(
   parameter int W     = 32,
   parameter int RADIX = 10
) (
   input  logic [W-1:0] i_acc,
   input  logic [3:0]   i_digit,
   output logic [W-1:0] o_acc,
   output logic         o_ovf
);

   localparam int XW = W + 4;
   localparam logic [XW-1:0] MAX_POS = {5'b0, {(W-1){1'b1}}};

   logic [XW-1:0] w_prod;
   logic [XW-1:0] w_sum;

   // Four guard bits hold acc*16+15 even when acc sits at the clamp value.
   always_comb begin
      w_prod = {4'b0, i_acc} * XW'(RADIX);
      w_sum  = w_prod + {{W{1'b0}}, i_digit};
      o_ovf  = (w_sum > MAX_POS);
      o_acc  = o_ovf ? MAX_POS[W-1:0] : w_sum[W-1:0];
   end

endmodule

// File: rtl/controller_num_entry.sv
// Number-entry engine: edit a signed digit buffer, convert MSD-first to binary on COMMIT.
// Result valid count+1 cycles after COMMIT, held until num_ready; commands stalled (cmd_ready=0) meanwhile.
module controller_num_entry
   import controller_num_entry_pkg::*;
#(
   parameter int DIGITS = 8,
   parameter int RADIX  = 10,
   parameter int W      = 32
) (
   input  logic                         Clock,
   input  logic                         Reset,
   input  logic                         cmd_valid,
   input  logic [2:0]                   cmd_op,
   input  logic [3:0]                   cmd_digit,
   output logic                         cmd_ready,
   output logic                         cmd_err,
   output logic [4*DIGITS-1:0]          buf_Q,
   output logic [$clog2(DIGITS+1)-1:0]  count_Q,
   output logic                         neg_Q,
   output logic [W-1:0]                 num_D,
   output logic                         num_valid,
   input  logic                         num_ready,
   output logic                         num_ovf
);

   localparam int CW = $clog2(DIGITS + 1);

   ne_state_t           r_state, w_state_nxt;
   logic [4*DIGITS-1:0] r_buf, w_buf_up, w_buf_dn;
   logic [CW-1:0]       r_count, r_idx;
   logic                r_neg, r_err, r_done, r_ovf, r_num_ovf;
   logic [W-1:0]        r_acc, r_num, w_mac_acc;
   logic                w_mac_ovf, w_cmd_acc, w_dig_bad, w_dig_lead;
   logic [3:0]          w_cur_dig;

   assign w_cmd_acc  = cmd_valid && (r_state == S_ENTRY);
   assign w_dig_bad  = ({1'b0, cmd_digit} >= 5'(RADIX)) || (r_count == CW'(DIGITS));
   assign w_dig_lead = (r_count == '0) && (cmd_digit == 4'd0);
   assign w_cur_dig  = r_buf[{r_idx, 2'b00} +: 4];

   controller_num_mac #(.W(W), .RADIX(RADIX)) u_mac (
      .i_acc   (r_acc),
      .i_digit (w_cur_dig),
      .o_acc   (w_mac_acc),
      .o_ovf   (w_mac_ovf)
   );

   always_comb begin
      w_buf_up      = r_buf << 4;
      w_buf_up[3:0] = cmd_digit;
      w_buf_dn      = r_buf >> 4;
      w_buf_dn[4*DIGITS-1 -: 4] = NE_BLANK;
   end

   always_comb begin
      w_state_nxt = r_state;
      cmd_ready   = 1'b0;
      num_valid   = 1'b0;
      case (r_state)
         S_ENTRY: begin
            cmd_ready = 1'b1;
            if (w_cmd_acc && (cmd_op == NE_OP_COMMIT)) w_state_nxt = S_CONV;
         end
         S_CONV: if (r_done) w_state_nxt = S_OUT;
         S_OUT: begin
            num_valid = 1'b1;
            if (num_ready) w_state_nxt = S_ENTRY;
         end
         default: w_state_nxt = S_ENTRY;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (!Reset) begin
         r_state   <= S_ENTRY;
         r_buf     <= {DIGITS{NE_BLANK}};
         r_count   <= '0;
         r_neg     <= 1'b0;
         r_err     <= 1'b0;
         r_acc     <= '0;
         r_idx     <= '0;
         r_done    <= 1'b0;
         r_ovf     <= 1'b0;
         r_num     <= '0;
         r_num_ovf <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_err   <= 1'b0;
         case (r_state)
            S_ENTRY: if (w_cmd_acc) begin
               case (cmd_op)
                  NE_OP_DIGIT: begin
                     if (w_dig_bad) r_err <= 1'b1;
                     else if (!w_dig_lead) begin
                        r_buf   <= w_buf_up;
                        r_count <= r_count + 1'b1;
                     end
                  end
                  NE_OP_BKSP: if (r_count != '0) begin
                     r_buf   <= w_buf_dn;
                     r_count <= r_count - 1'b1;
                  end
                  NE_OP_CLEAR: begin
                     r_buf   <= {DIGITS{NE_BLANK}};
                     r_count <= '0;
                     r_neg   <= 1'b0;
                  end
                  NE_OP_NEG: r_neg <= ~r_neg;
                  NE_OP_COMMIT: begin
                     // An empty buffer still spends one S_CONV cycle so latency is always count+1.
                     r_acc  <= '0;
                     r_ovf  <= 1'b0;
                     r_idx  <= r_count - 1'b1;
                     r_done <= (r_count == '0);
                  end
                  default: ;
               endcase
            end
            S_CONV: begin
               if (r_done) begin
                  r_num     <= r_neg ? (~r_acc + 1'b1) : r_acc;
                  r_num_ovf <= r_ovf;
               end else begin
                  r_acc  <= w_mac_acc;
                  r_ovf  <= r_ovf | w_mac_ovf;
                  r_done <= (r_idx == '0);
                  r_idx  <= r_idx - 1'b1;
               end
            end
            S_OUT: if (num_ready) begin
               r_buf   <= {DIGITS{NE_BLANK}};
               r_count <= '0;
               r_neg   <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign cmd_err = r_err;
   assign buf_Q   = r_buf;
   assign count_Q = r_count;
   assign neg_Q   = r_neg;
   assign num_D   = r_num;
   assign num_ovf = r_num_ovf;

endmodule

// File: tb/tb_controller_num_entry.sv
// Scoreboard bench: W=32 and W=16 instances share stimulus; expected operands queued at COMMIT.
module tb_controller_num_entry;
   import controller_num_entry_pkg::*;

   localparam int DIGITS = 8;
   localparam int RADIX  = 10;

   logic        Clock = 1'b0;
   logic        Reset = 1'b0;
   logic        cmd_valid = 1'b0;
   logic [2:0]  cmd_op = '0;
   logic [3:0]  cmd_digit = '0;
   logic        num_ready = 1'b0;

   logic        cmd_ready, cmd_err, neg_Q, num_valid, num_ovf;
   logic [31:0] buf_Q, num_D;
   logic [3:0]  count_Q;

   logic        h_cmd_ready, h_cmd_err, h_neg_Q, h_num_valid, h_num_ovf;
   logic [31:0] h_buf_Q;
   logic [15:0] h_num_D;
   logic [3:0]  h_count_Q;

   controller_num_entry #(.DIGITS(DIGITS), .RADIX(RADIX), .W(32)) dut (
      .Clock(Clock), .Reset(Reset), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_digit(cmd_digit),
      .cmd_ready(cmd_ready), .cmd_err(cmd_err), .buf_Q(buf_Q), .count_Q(count_Q), .neg_Q(neg_Q),
      .num_D(num_D), .num_valid(num_valid), .num_ready(num_ready), .num_ovf(num_ovf));

   controller_num_entry #(.DIGITS(DIGITS), .RADIX(RADIX), .W(16)) dut16 (
      .Clock(Clock), .Reset(Reset), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_digit(cmd_digit),
      .cmd_ready(h_cmd_ready), .cmd_err(h_cmd_err), .buf_Q(h_buf_Q), .count_Q(h_count_Q), .neg_Q(h_neg_Q),
      .num_D(h_num_D), .num_valid(h_num_valid), .num_ready(num_ready), .num_ovf(h_num_ovf));

   always #5 Clock = ~Clock;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference model: digits most significant first, sign, pending results.
   int          mq[$];
   bit          m_neg = 1'b0;
   logic        m_err = 1'b0;
   logic [32:0] sb32[$];
   logic [32:0] sb16[$];

   function automatic logic [31:0] exp_buf();
      logic [31:0] b = '1;
      for (int i = 0; i < mq.size(); i++) b[4*i +: 4] = 4'(mq[mq.size()-1-i]);
      return b;
   endfunction

   function automatic logic [32:0] conv(input int w);
      longint acc = 0;
      longint mx  = (longint'(1) << (w - 1)) - 1;
      longint r;
      logic   o = 1'b0;
      foreach (mq[i]) begin
         acc = acc * RADIX + mq[i];
         if (acc > mx) begin
            acc = mx;
            o   = 1'b1;
         end
      end
      r = m_neg ? -acc : acc;
      r = r & ((longint'(1) << w) - 1);
      return {o, r[31:0]};
   endfunction

   task automatic cmd(input logic [2:0] op, input logic [3:0] d);
      bit acc;
      @(negedge Clock);
      acc = cmd_ready;
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_digit = d;
      m_err     = 1'b0;
      if (acc) begin
         case (op)
            NE_OP_DIGIT: begin
               if (d >= RADIX || mq.size() == DIGITS) m_err = 1'b1;
               else if (!(mq.size() == 0 && d == 4'd0)) mq.push_back(int'(d));
            end
            NE_OP_BKSP:   if (mq.size() > 0) void'(mq.pop_back());
            NE_OP_CLEAR:  begin mq.delete(); m_neg = 1'b0; end
            NE_OP_NEG:    m_neg = !m_neg;
            NE_OP_COMMIT: begin sb32.push_back(conv(32)); sb16.push_back(conv(16)); end
            default: ;
         endcase
      end
      @(negedge Clock);
      cmd_valid = 1'b0;
      chk("cmd_err", cmd_err, m_err);
      chk("count", count_Q, mq.size());
      chk("buf", buf_Q, exp_buf());
      chk("neg", neg_Q, m_neg);
   endtask

   task automatic commit_wait();
      int k = 0;
      int n = mq.size();
      cmd(NE_OP_COMMIT, 4'd0);
      while (!num_valid && k < 64) begin
         @(negedge Clock);
         k++;
      end
      chk("latency", k, n + 1);
   endtask

   task automatic finish_out();
      int k = 0;
      num_ready = 1'b1;
      while (num_valid && k < 64) begin
         @(negedge Clock);
         k++;
      end
      chk("hs_done", k < 64, 1);
      mq.delete();
      m_neg = 1'b0;
      chk("drain", sb32.size(), 0);
      chk("ready_back", cmd_ready, 1);
      chk("count_clr", count_Q, 0);
      chk("buf_clr", buf_Q, 32'hffff_ffff);
      chk("neg_clr", neg_Q, 0);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_ready"}, cmd_ready, 1);
      chk({tag, "_err"}, cmd_err, 0);
      chk({tag, "_buf"}, buf_Q, 32'hffff_ffff);
      chk({tag, "_count"}, count_Q, 0);
      chk({tag, "_neg"}, neg_Q, 0);
      chk({tag, "_num"}, num_D, 0);
      chk({tag, "_valid"}, num_valid, 0);
      chk({tag, "_ovf"}, num_ovf, 0);
      chk({tag, "_valid16"}, h_num_valid, 0);
   endtask

   // Output side: pop and compare on every handshake.
   initial forever begin
      logic [32:0] e;
      @(negedge Clock);
      #1;
      if (Reset && num_valid && num_ready) begin
         chk("sb_pending", sb32.size() != 0, 1);
         chk("valid16", h_num_valid, 1);
         if (sb32.size() != 0) begin
            e = sb32.pop_front();
            chk("num_D", num_D, e[31:0]);
            chk("num_ovf", num_ovf, e[32]);
         end
         if (sb16.size() != 0) begin
            e = sb16.pop_front();
            chk("num_D16", h_num_D, e[15:0]);
            chk("num_ovf16", h_num_ovf, e[32]);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      repeat (2) @(negedge Clock);
      chk_reset_vals("rst0");
      Reset = 1'b1;
      num_ready = 1'b1;

      cmd(NE_OP_DIGIT, 4'd1);
      cmd(NE_OP_DIGIT, 4'd2);
      cmd(NE_OP_DIGIT, 4'd3);
      chk("buf_123", buf_Q[11:0], 12'h123);
      commit_wait();
      finish_out();

      cmd(NE_OP_DIGIT, 4'd0);
      cmd(NE_OP_DIGIT, 4'd0);
      cmd(NE_OP_DIGIT, 4'd7);
      cmd(NE_OP_NEG, 4'd0);
      commit_wait();
      chk("neg7", num_D, 32'hffff_fff9);
      finish_out();

      cmd(NE_OP_DIGIT, 4'hA);
      for (int i = 1; i <= DIGITS; i++) cmd(NE_OP_DIGIT, 4'(i));
      cmd(NE_OP_DIGIT, 4'd9);
      chk("full_count", count_Q, DIGITS);
      cmd(NE_OP_BKSP, 4'd0);
      cmd(NE_OP_NEG, 4'd0);
      cmd(NE_OP_CLEAR, 4'd0);

      for (int i = 0; i < 5; i++) cmd(NE_OP_DIGIT, 4'd9);
      commit_wait();
      chk("sat16", h_num_D, 16'h7fff);
      chk("sat16_ovf", h_num_ovf, 1);
      finish_out();

      cmd(NE_OP_DIGIT, 4'd4);
      cmd(NE_OP_DIGIT, 4'd5);
      cmd(NE_OP_BKSP, 4'd0);
      cmd(NE_OP_BKSP, 4'd0);
      cmd(NE_OP_BKSP, 4'd0);
      commit_wait();
      finish_out();

      num_ready = 1'b0;
      cmd(NE_OP_DIGIT, 4'd4);
      cmd(NE_OP_DIGIT, 4'd2);
      commit_wait();
      for (int i = 0; i < 5; i++) begin
         chk("stall_valid", num_valid, 1);
         chk("stall_ready", cmd_ready, 0);
         if (sb32.size() != 0) chk("stall_num", num_D, sb32[0][31:0]);
         cmd(NE_OP_DIGIT, 4'd3);
      end
      finish_out();

      for (int i = 1; i <= 6; i++) cmd(NE_OP_DIGIT, 4'(i));
      cmd(NE_OP_COMMIT, 4'd0);
      sb32.push_back(33'd0);
      void'(sb32.pop_back());
      @(negedge Clock);
      Reset = 1'b0;
      @(negedge Clock);
      chk_reset_vals("rst_conv");
      sb32.delete();
      sb16.delete();
      mq.delete();
      m_neg = 1'b0;
      Reset = 1'b1;
      cmd(NE_OP_DIGIT, 4'd5);
      commit_wait();
      finish_out();

      for (int r = 0; r < 4; r++) begin
         int n = $urandom_range(0, DIGITS);
         for (int i = 0; i < n; i++) cmd(NE_OP_DIGIT, 4'($urandom_range(0, 9)));
         if ($urandom_range(0, 1) == 1) cmd(NE_OP_NEG, 4'd0);
         commit_wait();
         finish_out();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
